// File: rtl/spike_rate_demapper_if.sv
// Bundle of the frame control, serial bit stream and decoded-rate handshake
// signals of the spike rate demapper. The demapper takes the slave view; the
// deserialiser/consumer side (or a bench) takes the master view.
interface spike_rate_demapper_if #(
    parameter int SPIKE_RATE_BIT = 3,
    parameter int CH_W           = 4
);
    logic                      frame_start;
    logic [SPIKE_RATE_BIT-1:0] max_rate_in;
    logic                      bit_in;
    logic                      bit_valid;
    logic                      bit_ready;
    logic [SPIKE_RATE_BIT-1:0] rate_out;
    logic                      rate_valid;
    logic                      rate_ready;
    logic [CH_W-1:0]           ch_idx;
    logic                      frame_done;
    logic                      err;

    modport master (
        output frame_start, max_rate_in, bit_in, bit_valid, rate_ready,
        input  bit_ready, rate_out, rate_valid, ch_idx, frame_done, err
    );

    modport slave (
        input  frame_start, max_rate_in, bit_in, bit_valid, rate_ready,
        output bit_ready, rate_out, rate_valid, ch_idx, frame_done, err
    );
endinterface

// File: rtl/spike_rate_demapper.sv
// Receive-side spike rate demapper: decodes a serial truncated-unary symbol
// stream (idx0="0" .. idx3="1110", idx4="1111"), inverse-maps each symbol
// index to a binned spike rate using the frame's max_rate, and hands the
// rates out one channel at a time over a valid/ready handshake. A frame is
// CHANNELS symbols long; frame_start mid-frame aborts and restarts it.
module spike_rate_demapper #(
    parameter int SPIKE_RATE_BIT = 3,
    parameter int CHANNELS       = 16,
    parameter int CH_W           = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_rate_demapper_if.slave  bus
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_DECODE = 1'b1
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_ones_cnt;
    logic [CH_W-1:0]           r_sym_cnt;
    logic [SPIKE_RATE_BIT-1:0] r_max_rate;
    logic [SPIKE_RATE_BIT-1:0] r_rate_out;
    logic                      r_rate_valid;
    logic [CH_W-1:0]           r_ch_idx;
    logic                      r_frame_done;
    logic                      r_err;

    logic                      w_bit_ready;
    logic                      w_accept;
    logic                      w_complete;
    logic [2:0]                w_idx;
    logic                      w_last_sym;

    // Inverse of the transmit-side rate-to-index mapping. Each row is packed
    // with idx4 in the top field so that row[idx] yields the rate directly.
    function automatic logic [SPIKE_RATE_BIT-1:0] f_inv_map(
        input logic [SPIKE_RATE_BIT-1:0] mr,
        input logic [2:0]                idx
    );
        logic [4:0][2:0] row;
        if (mr == SPIKE_RATE_BIT'(0))
            row = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        else if (mr == SPIKE_RATE_BIT'(1))
            row = {3'd4, 3'd3, 3'd2, 3'd0, 3'd1};
        else if (mr == SPIKE_RATE_BIT'(2))
            row = {3'd4, 3'd2, 3'd0, 3'd1, 3'd3};
        else if (mr == SPIKE_RATE_BIT'(3))
            row = {3'd2, 3'd0, 3'd1, 3'd3, 3'd4};
        else
            row = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        return SPIKE_RATE_BIT'(row[idx]);
    endfunction

    // Bits are refused while restarting a frame or while a decoded rate is
    // stalled downstream, so a completed symbol can never overwrite one that
    // has not been consumed.
    assign w_bit_ready = (r_state == S_DECODE) && !bus.frame_start &&
                         (!r_rate_valid || bus.rate_ready);
    assign w_accept    = bus.bit_valid && w_bit_ready;
    // A zero terminates any codeword; a fourth consecutive one is idx4.
    assign w_complete  = w_accept && (!bus.bit_in || (r_ones_cnt == 2'd3));
    assign w_idx       = bus.bit_in ? 3'd4 : {1'b0, r_ones_cnt};
    assign w_last_sym  = (r_sym_cnt == CH_W'(CHANNELS - 1));

    // Frame FSM, codeword decoder and registered output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ones_cnt   <= 2'd0;
            r_sym_cnt    <= '0;
            r_max_rate   <= '0;
            r_rate_out   <= '0;
            r_rate_valid <= 1'b0;
            r_ch_idx     <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;

            if (r_rate_valid && bus.rate_ready)
                r_rate_valid <= 1'b0;

            if (bus.frame_start) begin
                // Restart: a pending output word is left alone until consumed.
                if ((r_state == S_DECODE) &&
                    ((r_sym_cnt != '0) || (r_ones_cnt != 2'd0)))
                    r_err <= 1'b1;
                r_max_rate <= bus.max_rate_in;
                r_sym_cnt  <= '0;
                r_ones_cnt <= 2'd0;
                r_state    <= S_DECODE;
            end else if (w_accept) begin
                if (w_complete) begin
                    r_ones_cnt   <= 2'd0;
                    r_rate_out   <= f_inv_map(r_max_rate, w_idx);
                    r_ch_idx     <= r_sym_cnt;
                    r_rate_valid <= 1'b1;
                    if (w_last_sym) begin
                        r_frame_done <= 1'b1;
                        r_sym_cnt    <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                end else begin
                    r_ones_cnt <= r_ones_cnt + 2'd1;
                end
            end
        end
    end

    assign bus.bit_ready  = w_bit_ready;
    assign bus.rate_out   = r_rate_out;
    assign bus.rate_valid = r_rate_valid;
    assign bus.ch_idx     = r_ch_idx;
    assign bus.frame_done = r_frame_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_spike_rate_demapper.sv
// Bench for spike_rate_demapper: directed bit streams, a symbol-level model
// of the expected rate stream and pulses, and one compare process on the
// falling edge plus literal checks of the decoded sequences.
module tb_spike_rate_demapper;

    localparam int SRB = 3;
    localparam int CHN = 16;
    localparam int CHW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_rate_demapper_if #(.SPIKE_RATE_BIT(SRB), .CH_W(CHW)) bus ();

    spike_rate_demapper #(
        .SPIKE_RATE_BIT(SRB),
        .CHANNELS      (CHN),
        .CH_W          (CHW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Inverse-map table straight from the rate definition: tbl[max_rate][idx].
    int tbl [5][5] = '{'{0, 1, 2, 3, 4},
                       '{1, 0, 2, 3, 4},
                       '{3, 1, 0, 2, 4},
                       '{4, 3, 1, 0, 2},
                       '{4, 3, 2, 1, 0}};

    // Model state.
    bit m_active = 1'b0;
    int m_mr     = 0;
    int m_ones   = 0;
    int m_sym    = 0;
    int fd_cyc   = -1;
    int err_cyc  = -1;
    int fd_ch    = -1;
    int q_rate[$];
    int q_ch[$];
    int log_rate[$];
    int log_ch[$];

    function automatic void chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_ones   = 0;
        m_sym    = 0;
        fd_cyc   = -1;
        err_cyc  = -1;
        q_rate.delete();
        q_ch.delete();
    endfunction

    function automatic void model_frame(int mr);
        if (m_active && (m_sym != 0 || m_ones != 0)) err_cyc = cyc;
        m_active = 1'b1;
        m_mr     = (mr > 4) ? 4 : mr;
        m_sym    = 0;
        m_ones   = 0;
    endfunction

    function automatic void model_bit(bit b);
        int idx;
        if (b && m_ones < 3) begin
            m_ones++;
        end else begin
            idx    = b ? 4 : m_ones;
            m_ones = 0;
            q_rate.push_back(tbl[m_mr][idx]);
            q_ch.push_back(m_sym);
            if (m_sym == CHN - 1) begin
                fd_cyc   = cyc;
                m_active = 1'b0;
                m_sym    = 0;
            end else begin
                m_sym++;
            end
        end
    endfunction

    // Compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        chk("rate_valid", int'(bus.rate_valid), (q_rate.size() != 0) ? 1 : 0);
        if (q_rate.size() != 0) begin
            chk("rate_out", int'(bus.rate_out), q_rate[0]);
            chk("ch_idx", int'(bus.ch_idx), q_ch[0]);
            if (bus.rate_valid && bus.rate_ready) begin
                log_rate.push_back(int'(bus.rate_out));
                log_ch.push_back(int'(bus.ch_idx));
                void'(q_rate.pop_front());
                void'(q_ch.pop_front());
            end
        end
        chk("frame_done", int'(bus.frame_done), (cyc == fd_cyc) ? 1 : 0);
        if (bus.frame_done) fd_ch = int'(bus.ch_idx);
        chk("err", int'(bus.err), (cyc == err_cyc) ? 1 : 0);
    end

    // All driving tasks are entered 1 time unit after a rising edge.
    task automatic do_frame(input int mr);
        bus.max_rate_in = SRB'(mr);
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        model_frame(mr);
        bus.frame_start = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        bit done;
        done          = 1'b0;
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            if (bus.bit_ready) begin
                @(posedge clk); #1;
                model_bit(b);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk("bit_accept_timeout", 0, 1);
    endtask

    task automatic send_bits(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "1") send_bit(1'b1);
            else if (s[i] == "0") send_bit(1'b0);
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Literal check of the handshaken word `back` entries from the end.
    task automatic check_sym(input string nm, input int back, input int r, input int c);
        if (log_rate.size() < back) begin
            chk({nm, "_count"}, log_rate.size(), back);
        end else begin
            chk({nm, "_rate"}, log_rate[log_rate.size() - back], r);
            chk({nm, "_ch"}, log_ch[log_ch.size() - back], c);
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.max_rate_in = '0;
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.rate_ready  = 1'b1;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rate_out", int'(bus.rate_out), 0);
        chk("rst_rate_valid", int'(bus.rate_valid), 0);
        chk("rst_ch_idx", int'(bus.ch_idx), 0);
        chk("rst_bit_ready", int'(bus.bit_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All five codewords under each of three mappings.
        do_frame(0);
        send_bits("0 10 110 1110 1111");
        drain();
        for (int i = 0; i < 5; i++) check_sym("map0", 5 - i, i, i);

        do_frame(3);
        chk("restart_err", int'(bus.err), 1);
        send_bits("0 10 110 1110 1111");
        drain();
        check_sym("map3_0", 5, 4, 0);
        check_sym("map3_1", 4, 3, 1);
        check_sym("map3_2", 3, 1, 2);
        check_sym("map3_3", 2, 0, 3);
        check_sym("map3_4", 1, 2, 4);

        do_frame(6);
        send_bits("0 10 110 1110 1111");
        drain();
        for (int i = 0; i < 5; i++) check_sym("map6", 5 - i, 4 - i, i);

        // Full frame of idx0 with max_rate 2, then IDLE refuses bits.
        do_frame(2);
        send_bits("0000000000000000");
        drain();
        for (int i = 0; i < CHN; i++) check_sym("full", CHN - i, 3, i);
        chk("frame_done_ch", fd_ch, CHN - 1);
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_bit_ready", int'(bus.bit_ready), 0);
        end
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;

        // Downstream stall after the first symbol.
        bus.rate_ready = 1'b0;
        do_frame(5);
        chk("idle_start_no_err", int'(bus.err), 0);
        send_bit(1'b0);
        fork
            send_bits("10 110");
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_bit_ready", int'(bus.bit_ready), 0);
                    chk("hold_rate", int'(bus.rate_out), 4);
                    chk("hold_ch", int'(bus.ch_idx), 0);
                end
                @(posedge clk); #1;
                bus.rate_ready = 1'b1;
            end
        join
        drain();
        check_sym("hold_s0", 3, 4, 0);
        check_sym("hold_s1", 2, 3, 1);
        check_sym("hold_s2", 1, 2, 2);

        // Abort after a partial codeword.
        do_frame(1);
        send_bits("11");
        do_frame(1);
        chk("abort_err", int'(bus.err), 1);
        send_bits("0");
        drain();
        check_sym("after_abort", 1, 1, 0);

        // Asynchronous reset mid-codeword.
        do_frame(4);
        send_bits("111");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_rate_out", int'(bus.rate_out), 0);
        chk("arst_rate_valid", int'(bus.rate_valid), 0);
        chk("arst_ch_idx", int'(bus.ch_idx), 0);
        chk("arst_frame_done", int'(bus.frame_done), 0);
        chk("arst_err", int'(bus.err), 0);
        chk("arst_bit_ready", int'(bus.bit_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_frame(4);
        chk("post_rst_no_err", int'(bus.err), 0);
        send_bits("0");
        drain();
        check_sym("post_rst", 1, 4, 0);

        chk("queue_empty", q_rate.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_demapper.md
Name: spike_rate_demapper

Overview:
- Receive-side counterpart of the transmit-side rate mapper/encoder.
- Accepts the serial truncated-unary symbol stream, decodes each symbol index 0..4, and inverse-maps it to the original binned spike rate using the frame's max_rate.
- Emits one rate per channel with a valid/ready handshake and frames the channels into groups of CHANNELS symbols.
- Sits between the link deserialiser and the rate reconstruction/storage logic.

Parameters:
- SPIKE_RATE_BIT, 3, width of rate and max_rate words.
- CHANNELS, 16, symbols per frame (must be >= 1).
- CH_W, 4, width of ch_idx; CHANNELS <= 2^CH_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- frame_start  in  1  one-cycle pulse that starts a frame and latches max_rate_in.
- max_rate_in  in  SPIKE_RATE_BIT  mapping selector for the frame; sampled only when frame_start=1.
- bit_in  in  1  serial code bit, first bit of each codeword first.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  block accepts bit this cycle.
- rate_out  out  SPIKE_RATE_BIT  decoded spike rate.
- rate_valid  out  1  rate_out/ch_idx valid.
- rate_ready  in  1  downstream accepts rate_out.
- ch_idx  out  CH_W  channel number of rate_out (0..CHANNELS-1).
- frame_done  out  1  one-cycle pulse; the final symbol of the frame has been decoded.
- err  out  1  one-cycle pulse; a frame was aborted mid-frame.

Behaviour:
- Reset (async, asserted): state=IDLE, ones_cnt=0, sym_cnt=0, max_rate_q=0, all outputs 0.
- States:
  - IDLE: bit_ready=0. On frame_start, latch max_rate_q=max_rate_in, clear sym_cnt and ones_cnt, and go to DECODE.
  - DECODE: decode bits until sym_cnt reaches CHANNELS.
- bit_ready = (state==DECODE) && !frame_start && (!rate_valid || rate_ready). A bit is accepted when bit_valid && bit_ready.
- Code (truncated unary):
  - idx0 = "0", idx1 = "10", idx2 = "110", idx3 = "1110", idx4 = "1111".
  - On an accepted 0: idx = ones_cnt; ones_cnt cleared.
  - On an accepted 1 with ones_cnt==3: idx = 4; ones_cnt cleared.
  - On any other accepted 1: ones_cnt+1, and no symbol is produced.
- Inverse map (idx0..idx4 -> rate), selected by max_rate_q:
  - 0: 0,1,2,3,4
  - 1: 1,0,2,3,4
  - 2: 3,1,0,2,4
  - 3: 4,3,1,0,2
  - >=4: 4,3,2,1,0
- Latency: rate_out, ch_idx=sym_cnt and rate_valid=1 are registered on the clock edge after the completing bit is accepted. sym_cnt then increments.
- Output hold: while rate_valid && !rate_ready, rate_out and ch_idx are held stable and no bits are accepted.
  - rate_valid clears on handshake unless a new symbol completes in the same cycle. A back-to-back handshake plus completion is legal and yields a continuous valid.
- Frame end:
  - When the symbol with ch_idx=CHANNELS-1 is registered, frame_done pulses high in the same cycle rate_valid first rises for it.
  - State returns to IDLE. The pending output is still delivered through the normal handshake.
- frame_start while in DECODE (abort/restart):
  - If sym_cnt!=0 or ones_cnt!=0, err pulses for one cycle.
  - Counters clear, max_rate is relatched, and the block stays in DECODE.
  - A pending rate_valid word is kept until consumed.
- frame_start in the same cycle as the final-symbol completion cannot occur, because bit_ready is forced low. frame_start in IDLE never sets err.
- Async reset mid-frame: all state is discarded immediately and no pulse is generated.

Test Plan:
- Reset, frame_start with max_rate_in=0, then stream "0 10 110 1110 1111", rate_ready=1 -> rates 0,1,2,3,4 with ch_idx 0..4, each valid 1 cycle after its last bit.
- max_rate_in=3, same stream -> rates 4,3,1,0,2. max_rate_in=6 -> 4,3,2,1,0.
- CHANNELS=16, 16 symbols "0", max_rate=2 -> sixteen rates of 3. frame_done pulses with ch_idx=15. Then IDLE with bit_ready=0 while bit_valid=1.
- Hold rate_ready=0 after the first symbol -> bit_ready=0 and rate_out/ch_idx stable for 5 cycles. Release -> decoding resumes with no lost or duplicated bits.
- Send "11", then frame_start -> err pulse, ones_cnt cleared. Next "0" decodes as idx0 with ch_idx=0.
- Assert rst mid-codeword after "111" -> all outputs 0 immediately. After frame_start, "0" -> idx0, with no err.
